// File: rtl/fifo_pkg.sv
// fifo_pkg: read-latency constant, beat type and width helper shared by the FIFO packer/unpacker pair.
// Rev 1.0
`default_nettype none

package fifo_pkg;

   // Cycles from an accepted pop to the word appearing on rdata.
   localparam int RD_LAT = 1;

   // Beat layout of the default 4 x 8-bit configuration, used on the interchange between the two sides.
   localparam int BEAT_DATA_W = 32;
   localparam int BEAT_CNT_W  = 3;

   typedef struct packed {
      logic [BEAT_DATA_W-1:0] data;
      logic [BEAT_CNT_W-1:0]  count;
   } beat_t;

   // Bits needed to hold a lane count of 0..ratio.
   function automatic int cnt_width(input int ratio);
      return $clog2(ratio + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_rd_skid_q.sv
// fifo_rd_skid_q: 2-entry valid/ready output queue; head is held until accepted.
// Rev 1.0
`default_nettype none

module fifo_rd_skid_q #(
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             enq_valid_i,
   input  logic [WIDTH-1:0] enq_data_i,
   input  logic             deq_ready_i,
   output logic             deq_valid_o,
   output logic [WIDTH-1:0] deq_data_o,
   output logic [1:0]       cnt_o
);

   logic [WIDTH-1:0] slot0_q, slot0_d;
   logic [WIDTH-1:0] slot1_q, slot1_d;
   logic [1:0]       cnt_q, cnt_d;
   logic             deq;
   logic             enq;

   always_comb begin
      slot0_d = slot0_q;
      slot1_d = slot1_q;
      cnt_d   = cnt_q;
      deq     = (cnt_q != 2'd0) && deq_ready_i;
      // A full queue still accepts a write in the cycle its head leaves.
      enq     = enq_valid_i && ((cnt_q != 2'd2) || deq);
      case ({enq, deq})
         2'b10: begin
            if (cnt_q == 2'd0) slot0_d = enq_data_i;
            else               slot1_d = enq_data_i;
            cnt_d = cnt_q + 2'd1;
         end
         2'b01: begin
            if (cnt_q == 2'd2) slot0_d = slot1_q;
            cnt_d = cnt_q - 2'd1;
         end
         2'b11: begin
            if (cnt_q == 2'd1) begin
               slot0_d = enq_data_i;
            end else begin
               slot0_d = slot1_q;
               slot1_d = enq_data_i;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         slot0_q <= '0;
         slot1_q <= '0;
         cnt_q   <= 2'd0;
      end else begin
         slot0_q <= slot0_d;
         slot1_q <= slot1_d;
         cnt_q   <= cnt_d;
      end
   end

   assign deq_valid_o = (cnt_q != 2'd0);
   assign deq_data_o  = slot0_q;
   assign cnt_o       = cnt_q;

endmodule

`default_nettype wire

// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: pops narrow FIFO words, packs PACK_RATIO of them (lane 0 first) into beats, supports flush.
// Rev 1.0
`default_nettype none

module fifo_rd_packer
   import fifo_pkg::*;
#(
   parameter int  DATA_WIDTH = 8,
   parameter int  PACK_RATIO = 4,
   localparam int CNT_W      = cnt_width(PACK_RATIO)
) (
   input  logic                             rclk,
   input  logic                             rrst,
   input  logic                             rempty,
   input  logic [DATA_WIDTH-1:0]            rdata,
   output logic                             r_en,
   input  logic                             flush,
   output logic                             m_valid,
   input  logic                             m_ready,
   output logic [DATA_WIDTH*PACK_RATIO-1:0] m_data,
   output logic [CNT_W-1:0]                 m_count,
   output logic                             flush_done
);

   localparam int               BEAT_W    = DATA_WIDTH * PACK_RATIO;
   localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(PACK_RATIO - 1);
   localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(PACK_RATIO);

   typedef struct packed {
      logic [BEAT_W-1:0] data;
      logic [CNT_W-1:0]  count;
   } pbeat_t;

   if ((RD_LAT != 1) || (PACK_RATIO < 1)) begin : g_param_chk
      $error("fifo_rd_packer supports RD_LAT == 1 and PACK_RATIO >= 1 only");
   end

   logic [CNT_W-1:0]  lane_cnt_q, lane_cnt_d;
   logic [BEAT_W-1:0] lanes_q, lanes_d;
   logic              inflight_q, inflight_d;
   logic              flush_pend_q, flush_pend_d;
   logic              flush_done_q, flush_done_d;

   logic [1:0]        q_cnt;
   logic              deq;
   logic              q_free;
   logic              c_inf;
   logic              c_new;
   logic [CNT_W-1:0]  next_pos;
   int                credit_sum;
   logic              flush_fin;
   logic [BEAT_W-1:0] lanes_wr;
   logic              enq_valid;
   pbeat_t            enq_beat;
   pbeat_t            head;

   assign deq    = m_valid && m_ready;
   assign q_free = (q_cnt != 2'd2) || deq;

   // Reserve a queue slot for every beat that the in-flight word or the word popped now would complete.
   always_comb begin
      c_inf      = inflight_q && (lane_cnt_q == LAST_LANE);
      next_pos   = c_inf ? '0 : lane_cnt_q + CNT_W'(inflight_q);
      c_new      = (next_pos == LAST_LANE);
      credit_sum = int'(q_cnt) + int'(c_inf) + int'(c_new) - int'(deq);
      r_en       = !rrst && !rempty && !flush_pend_q && (credit_sum <= 2);
   end

   // A flush completes once nothing is in flight, no pop is issued this cycle and the queue can take a beat.
   always_comb begin
      flush_fin    = (flush_pend_q || flush) && !inflight_q && !r_en && q_free;
      flush_pend_d = (flush_pend_q || flush) && !flush_fin;
      flush_done_d = flush_fin;
      inflight_d   = r_en;
   end

   always_comb begin
      lanes_d    = lanes_q;
      lane_cnt_d = lane_cnt_q;
      enq_valid  = 1'b0;
      enq_beat   = '0;
      lanes_wr   = lanes_q;
      lanes_wr[int'(lane_cnt_q)*DATA_WIDTH +: DATA_WIDTH] = rdata;
      if (inflight_q) begin
         if (lane_cnt_q == LAST_LANE) begin
            enq_valid      = 1'b1;
            enq_beat.data  = lanes_wr;
            enq_beat.count = FULL_CNT;
            lanes_d        = '0;
            lane_cnt_d     = '0;
         end else begin
            lanes_d    = lanes_wr;
            lane_cnt_d = lane_cnt_q + CNT_W'(1);
         end
      end else if (flush_fin && (lane_cnt_q != '0)) begin
         // Lanes above lane_cnt are already zero since they are cleared after every beat.
         enq_valid      = 1'b1;
         enq_beat.data  = lanes_q;
         enq_beat.count = lane_cnt_q;
         lanes_d        = '0;
         lane_cnt_d     = '0;
      end
   end

   always_ff @(posedge rclk) begin
      if (rrst) begin
         lane_cnt_q   <= '0;
         lanes_q      <= '0;
         inflight_q   <= 1'b0;
         flush_pend_q <= 1'b0;
         flush_done_q <= 1'b0;
      end else begin
         lane_cnt_q   <= lane_cnt_d;
         lanes_q      <= lanes_d;
         inflight_q   <= inflight_d;
         flush_pend_q <= flush_pend_d;
         flush_done_q <= flush_done_d;
      end
   end

   fifo_rd_skid_q #(
      .WIDTH ($bits(pbeat_t))
   ) u_out_q (
      .clk_i       (rclk),
      .rst_i       (rrst),
      .enq_valid_i (enq_valid),
      .enq_data_i  (enq_beat),
      .deq_ready_i (m_ready),
      .deq_valid_o (m_valid),
      .deq_data_o  (head),
      .cnt_o       (q_cnt)
   );

   assign m_data     = head.data;
   assign m_count    = head.count;
   assign flush_done = flush_done_q;

endmodule

`default_nettype wire

// File: tb/tb_fifo_rd_packer.sv
// tb_fifo_rd_packer: directed bench for fifo_rd_packer with a behavioural FIFO read port.
// Rev 1.0
`default_nettype none

module tb_fifo_rd_packer;

   logic        rclk = 1'b0;
   logic        rrst = 1'b1;
   logic        rempty = 1'b1;
   logic [7:0]  rdata = 8'h00;
   logic        flush = 1'b0;
   logic        m_ready = 1'b0;
   logic        r_en;
   logic        m_valid;
   logic [31:0] m_data;
   logic [2:0]  m_count;
   logic        flush_done;

   fifo_rd_packer #(
      .DATA_WIDTH (8),
      .PACK_RATIO (4)
   ) dut (
      .rclk       (rclk),
      .rrst       (rrst),
      .rempty     (rempty),
      .rdata      (rdata),
      .r_en       (r_en),
      .flush      (flush),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_data     (m_data),
      .m_count    (m_count),
      .flush_done (flush_done)
   );

   always #5 rclk = ~rclk;

   logic [7:0]  fifo_q[$];
   logic [34:0] obs_q[$];
   int          tests_run = 0;
   int          tests_failed = 0;
   int          cyc = 0;
   int          pops = 0;
   int          first_pop = -1;
   int          last_pop = -1;
   int          first_beat_cyc = -1;
   int          last_beat_cyc = -1;
   int          fd_cnt = 0;
   int          fd_cyc = -1;
   int          viol_ren = 0;
   int          viol_stable = 0;
   int          hold = 0;
   bit          toggle_en = 0;
   bit          tog = 0;
   bit          rnd_ready = 0;
   bit          prev_stall = 0;
   logic [31:0] prev_data = '0;
   logic [2:0]  prev_count = '0;
   logic [7:0]  exp_w[24];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [34:0] bt(input logic [2:0] c, input logic [31:0] d);
      return {c, d};
   endfunction

   task automatic refresh();
      rempty = (fifo_q.size() == 0) || (toggle_en && tog);
      #1;
   endtask

   // Sample outputs, let one rising edge pass, then drive the next cycle's inputs.
   task automatic tick();
      bit popping;
      if (rrst) begin
         prev_stall = 0;
      end else begin
         if (prev_stall && (m_valid !== 1'b1 || m_data !== prev_data || m_count !== prev_count))
            viol_stable++;
         prev_stall = (m_valid === 1'b1) && !m_ready;
         prev_data  = m_data;
         prev_count = m_count;
      end
      if ((r_en === 1'b1) && rempty) viol_ren++;
      popping = (r_en === 1'b1) && !rempty;
      if (popping) begin
         pops++;
         if (first_pop < 0) first_pop = cyc;
         last_pop = cyc;
      end
      if (flush_done === 1'b1) begin
         fd_cnt++;
         fd_cyc = cyc;
      end
      if ((m_valid === 1'b1) && m_ready) begin
         if (obs_q.size() == 0) first_beat_cyc = cyc;
         last_beat_cyc = cyc;
         obs_q.push_back({m_count, m_data});
      end
      @(posedge rclk);
      @(negedge rclk);
      cyc++;
      rdata = popping ? fifo_q.pop_front() : 8'hEE;
      flush = 1'b0;
      if (toggle_en) tog = !tog;
      if (rnd_ready) begin
         if (hold > 0) begin
            m_ready = 1'b0;
            hold--;
         end else if ($urandom_range(0, 3) == 0) begin
            m_ready = 1'b0;
            hold = int'($urandom_range(0, 2));
         end else begin
            m_ready = 1'b1;
         end
      end
      refresh();
   endtask

   task automatic run_n(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic run_until(input int nbeats, input int budget);
      for (int k = 0; (k < budget) && (obs_q.size() < nbeats); k++) tick();
   endtask

   task automatic do_reset();
      rrst = 1'b1;
      flush = 1'b0;
      m_ready = 1'b0;
      toggle_en = 0;
      rnd_ready = 0;
      tog = 0;
      fifo_q.delete();
      refresh();
      tick();
      rrst = 1'b0;
      obs_q.delete();
      pops = 0;
      fd_cnt = 0;
      viol_ren = 0;
      viol_stable = 0;
      first_pop = -1;
      first_beat_cyc = -1;
      refresh();
   endtask

   initial begin
      int c0;
      // Reset state, then a preloaded FIFO must stay untouched while reset is held.
      refresh();
      tick();
      tick();
      check("rst_m_valid", m_valid, 0);
      check("rst_m_data", m_data, 0);
      check("rst_m_count", m_count, 0);
      check("rst_flush_done", flush_done, 0);
      for (int i = 1; i <= 8; i++) fifo_q.push_back(8'(i));
      refresh();
      check("rst_r_en_gated", r_en, 0);
      tick();
      check("rst_no_pop", pops, 0);
      rrst = 1'b0;
      m_ready = 1'b1;
      refresh();

      // Streaming at full rate.
      run_until(2, 40);
      check("stream_beats", obs_q.size(), 2);
      if (obs_q.size() == 2) begin
         check("stream_beat0", obs_q[0], bt(3'd4, 32'h04030201));
         check("stream_beat1", obs_q[1], bt(3'd4, 32'h08070605));
      end
      check("stream_pops", pops, 8);
      check("stream_pop_span", last_pop - first_pop, 7);
      check("stream_latency", first_beat_cyc - first_pop, 5);

      // Back-pressure: two beats queued, then pops stop at the credit limit.
      do_reset();
      for (int i = 1; i <= 8; i++) fifo_q.push_back(8'(i));
      refresh();
      run_n(20);
      check("bp_pops8", pops, 8);
      check("bp_no_beats", obs_q.size(), 0);
      check("bp_head_valid", m_valid, 1);
      check("bp_head_data", m_data, 32'h04030201);
      for (int i = 9; i <= 12; i++) fifo_q.push_back(8'(i));
      refresh();
      run_n(10);
      check("bp_credit_stall", pops, 11);
      m_ready = 1'b1;
      refresh();
      run_until(3, 30);
      check("bp_drain_beats", obs_q.size(), 3);
      if (obs_q.size() == 3) begin
         check("bp_beat0", obs_q[0], bt(3'd4, 32'h04030201));
         check("bp_beat1", obs_q[1], bt(3'd4, 32'h08070605));
         check("bp_beat2", obs_q[2], bt(3'd4, 32'h0C0B0A09));
      end
      check("bp_pops12", pops, 12);
      check("bp_stable", viol_stable, 0);

      // Partial beat on flush, then a flush with nothing pending.
      do_reset();
      m_ready = 1'b1;
      fifo_q.push_back(8'hAA);
      fifo_q.push_back(8'hBB);
      fifo_q.push_back(8'hCC);
      refresh();
      run_n(8);
      check("fl_no_early_beat", obs_q.size(), 0);
      flush = 1'b1;
      tick();
      run_n(6);
      check("fl_beats", obs_q.size(), 1);
      if (obs_q.size() == 1) check("fl_partial", obs_q[0], bt(3'd3, 32'h00CCBBAA));
      check("fl_done_cnt", fd_cnt, 1);
      check("fl_done_order", fd_cyc >= last_beat_cyc, 1);
      fd_cnt = 0;
      c0 = cyc;
      flush = 1'b1;
      tick();
      tick();
      check("fl_empty_done", fd_cnt, 1);
      check("fl_empty_done_cyc", fd_cyc, c0 + 1);
      run_n(4);
      check("fl_empty_single", fd_cnt, 1);
      check("fl_empty_no_beat", obs_q.size(), 1);
      check("fl_empty_valid", m_valid, 0);

      // Flush coinciding with the pop of the fourth word.
      do_reset();
      m_ready = 1'b1;
      fifo_q.push_back(8'h11);
      fifo_q.push_back(8'h22);
      fifo_q.push_back(8'h33);
      refresh();
      run_n(6);
      fifo_q.push_back(8'h44);
      refresh();
      flush = 1'b1;
      tick();
      run_n(8);
      check("fl4_pops", pops, 4);
      check("fl4_beats", obs_q.size(), 1);
      if (obs_q.size() == 1) check("fl4_full", obs_q[0], bt(3'd4, 32'h44332211));
      check("fl4_done", fd_cnt, 1);

      // Bursty FIFO and random back-pressure.
      do_reset();
      for (int i = 0; i < 24; i++) begin
         exp_w[i] = 8'(i * 37 + 5);
         fifo_q.push_back(exp_w[i]);
      end
      toggle_en = 1;
      rnd_ready = 1;
      m_ready = 1'b1;
      refresh();
      run_until(6, 600);
      check("rnd_beats", obs_q.size(), 6);
      for (int b = 0; b < 6; b++) begin
         if (b < obs_q.size())
            check($sformatf("rnd_beat%0d", b), obs_q[b],
                  bt(3'd4, {exp_w[4*b+3], exp_w[4*b+2], exp_w[4*b+1], exp_w[4*b]}));
      end
      check("rnd_ren_empty", viol_ren, 0);
      check("rnd_stable", viol_stable, 0);

      // Reset with a word in flight and one beat queued.
      do_reset();
      for (int i = 0; i < 5; i++) fifo_q.push_back(8'(8'h51 + i));
      refresh();
      for (int k = 0; (k < 20) && (pops < 5); k++) tick();
      check("mr_pops", pops, 5);
      check("mr_pre_valid", m_valid, 1);
      rrst = 1'b1;
      #1;
      check("mr_r_en_gated", r_en, 0);
      tick();
      rrst = 1'b0;
      refresh();
      check("mr_post_valid", m_valid, 0);
      check("mr_post_count", m_count, 0);
      m_ready = 1'b1;
      for (int i = 0; i < 4; i++) fifo_q.push_back(8'(8'h61 + i));
      refresh();
      run_until(1, 20);
      run_n(3);
      check("mr_beats", obs_q.size(), 1);
      if (obs_q.size() == 1) check("mr_clean_beat", obs_q[0], bt(3'd4, 32'h64636261));

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

`default_nettype wire
